// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-port unified instruction/data memory between two
//   requesters:
//     - port 0 (cpu): the multicycle CPU controller.
//     - port 1 (dbg): the debug/program loader.
//   When the arbiter is idle it picks one requester and latches that
//   request. It then drives the memory for LAT cycles. For a read, it
//   captures the read data at the end of the access. Finally it returns a
//   one-cycle acknowledge to the requester that won.
//
//   Transaction timeline (the request is sampled at edge N):
//     cycles N+1 .. N+LAT : BUSY, the memory strobes are active
//     cycle  N+LAT+1      : DONE, the winner's ack is high
//     next cycle          : IDLE, the arbiter can grant again
//
// Configuration:
//   MEM_ARB_RR_EN  defined     : round-robin on simultaneous requests.
//                                The port that was not granted last wins.
//   MEM_ARB_RR_EN  not defined : fixed priority. On simultaneous requests
//                                the dbg port always wins.
//   A single requester is always granted in both modes.
//
// Parameters:
//   AW   address width
//   DW   data width
//   LAT  memory access latency in cycles, legal range 1..15
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   i_cpu_req        port 0 request, held until o_cpu_ack
//   i_cpu_we         port 0 write (1) / read (0)
//   i_cpu_addr       port 0 address
//   i_cpu_wdata      port 0 write data
//   o_cpu_ack        port 0 one-cycle completion pulse
//   o_cpu_stall      i_cpu_req & ~o_cpu_ack (combinational)
//   i_dbg_*, o_dbg_ack
//                    port 1, with the same meaning as port 0
//   o_rdata          captured read data. It is valid with the ack pulse
//                    and held until the next read capture.
//   o_mem_addr, o_mem_wdata, o_mem_re, o_mem_we
//                    memory-side outputs. All are zero outside BUSY.
//   i_mem_rdata      memory read data, valid LAT cycles after o_mem_re
//                    first rises
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,

    // Port 0: CPU controller
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_ack,
    output logic          o_cpu_stall,

    // Port 1: debug / program loader
    input  logic          i_dbg_req,
    input  logic          i_dbg_we,
    input  logic [AW-1:0] i_dbg_addr,
    input  logic [DW-1:0] i_dbg_wdata,
    output logic          o_dbg_ack,

    // Read data returned to whichever port won
    output logic [DW-1:0] o_rdata,

    // Memory side
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_re,
    output logic          o_mem_we,
    input  logic [DW-1:0] i_mem_rdata
);

    // The 4-bit counter covers the full legal latency range 1..15.
    localparam int            CW       = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    // Latched transaction. The counter runs from LAT-1 down to 0 during BUSY.
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_win_dbg;     // 1: port 1 owns the current transaction
    logic [DW-1:0] r_rdata;

    logic          w_any_req;
    logic          w_grant;       // a new transaction is accepted at this edge
    logic          w_tie_dbg;     // winner when both ports request together
    logic          w_grant_dbg;   // the new transaction belongs to port 1
    logic          w_busy;
    logic          w_first_cycle;
    logic          w_last_cycle;
    logic          w_cpu_ack;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    assign w_any_req = i_cpu_req | i_dbg_req;

    // Arbitration happens only in IDLE. Requests seen in BUSY or DONE are
    // not remembered; a requester that drops its request before being
    // granted is simply never served.
    assign w_grant   = (r_state == S_IDLE) & w_any_req;

`ifdef MEM_ARB_RR_EN
    // 1 means port 1 won the most recent grant. It resets to port 1, so
    // the CPU wins the first tie after reset.
    logic r_last_dbg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_dbg <= 1'b1;
        end else if (w_grant) begin
            r_last_dbg <= w_grant_dbg;
        end
    end

    assign w_tie_dbg = ~r_last_dbg;
`else
    assign w_tie_dbg = 1'b1;
`endif

    // A lone request always wins. A tie is resolved by w_tie_dbg.
    assign w_grant_dbg = i_dbg_req & (~i_cpu_req | w_tie_dbg);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments, so every register
    // samples the values from before the edge regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: the next-state value is given a default first, so that no path
    // through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req)    w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last_cycle) w_state_nxt = S_DONE;
            S_DONE:                    w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: transaction latch, wait counter, read-data capture
    // -----------------------------------------------------------------------
    assign w_busy        = (r_state == S_BUSY);
    assign w_first_cycle = w_busy & (r_cnt == CNT_LOAD);
    assign w_last_cycle  = w_busy & (r_cnt == '0);

    // NOTE: the transaction registers are reset as well as the state. This
    // keeps their contents well defined right after reset, and o_rdata must
    // read zero out of reset in any case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_win_dbg <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_grant) begin
                r_cnt     <= CNT_LOAD;
                r_win_dbg <= w_grant_dbg;
                r_we      <= w_grant_dbg ? i_dbg_we    : i_cpu_we;
                r_addr    <= w_grant_dbg ? i_dbg_addr  : i_cpu_addr;
                r_wdata   <= w_grant_dbg ? i_dbg_wdata : i_cpu_wdata;
            end else if (w_busy && !w_last_cycle) begin
                r_cnt <= r_cnt - 1'b1;
            end

            // Capture read data on the last BUSY cycle. Writes leave
            // o_rdata untouched.
            if (w_last_cycle && !r_we) begin
                r_rdata <= i_mem_rdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: output logic
    // -----------------------------------------------------------------------
    // The outputs are decoded only from registers. Reset is asynchronous,
    // so the memory strobes drop as soon as rst_n goes low, even in the
    // middle of an access.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        w_cpu_ack   = 1'b0;
        o_dbg_ack   = 1'b0;
        case (r_state)
            S_BUSY: begin
                o_mem_addr  = r_addr;
                o_mem_wdata = r_wdata;
                o_mem_re    = ~r_we;
                // Pulse the write strobe once. For LAT=1 the first and the
                // last BUSY cycle are the same cycle.
                o_mem_we    = r_we & w_first_cycle;
            end
            S_DONE: begin
                w_cpu_ack = ~r_win_dbg;
                o_dbg_ack =  r_win_dbg;
            end
            default: ;
        endcase
    end

    assign o_cpu_ack   = w_cpu_ack;
    assign o_cpu_stall = i_cpu_req & ~w_cpu_ack;
    assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. It builds two instances:
//   - u_dut (LAT=2) is attached to a small 64-word memory model. The
//     memory's read data is only valid LAT cycles after the read strobe
//     rises.
//   - u_dut_l1 (LAT=1) is attached to a read-only pattern source.
// Expected results come from constant tables and from a transaction-level
// model. The model knows when a grant happens, when the ack is due, and the
// shadow memory contents.
// The bench checks the MEM_ARB_RR_EN build when that macro is defined, and
// the fixed-priority build otherwise.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int NRND = 1500;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A (LAT=2) ----------------
    logic        cpu_req = 0, cpu_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0;
    logic        cpu_ack, cpu_stall;
    logic        dbg_req = 0, dbg_we = 0;
    logic [31:0] dbg_addr = 0, dbg_wdata = 0;
    logic        dbg_ack;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ack(cpu_ack), .o_cpu_stall(cpu_stall),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_ack(dbg_ack),
        .o_rdata(rdata),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_re(mem_re), .o_mem_we(mem_we),
        .i_mem_rdata(mem_rdata)
    );

    // Memory model. Read data is valid only in the LAT-th cycle of a read
    // strobe; in earlier cycles it shows a junk pattern.
    logic [31:0] mem [64];
    bit          mem_ready = 0;
    int          re_cyc = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h1234_5678 : (32'h5000_0000 + 32'(i));
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
        re_cyc <= mem_re ? re_cyc + 1 : 0;
    end

    assign mem_rdata = (mem_re && re_cyc == LAT - 1) ? mem[mem_addr[7:2]]
                                                    : (32'hBAD0_0000 | 32'(re_cyc));

    // ---------------- DUT B (LAT=1) ----------------
    logic        b_cpu_req = 0, b_cpu_we = 0;
    logic [31:0] b_cpu_addr = 0, b_cpu_wdata = 0;
    logic        b_cpu_ack, b_cpu_stall;
    logic        b_dbg_req = 0, b_dbg_we = 0;
    logic [31:0] b_dbg_addr = 0, b_dbg_wdata = 0;
    logic        b_dbg_ack;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_re, b_mem_we;
    int          b_re_cyc = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .i_cpu_req(b_cpu_req), .i_cpu_we(b_cpu_we), .i_cpu_addr(b_cpu_addr), .i_cpu_wdata(b_cpu_wdata),
        .o_cpu_ack(b_cpu_ack), .o_cpu_stall(b_cpu_stall),
        .i_dbg_req(b_dbg_req), .i_dbg_we(b_dbg_we), .i_dbg_addr(b_dbg_addr), .i_dbg_wdata(b_dbg_wdata),
        .o_dbg_ack(b_dbg_ack),
        .o_rdata(b_rdata),
        .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata), .o_mem_re(b_mem_re), .o_mem_we(b_mem_we),
        .i_mem_rdata(b_mem_rdata)
    );

    always @(posedge clk) b_re_cyc <= b_mem_re ? b_re_cyc + 1 : 0;
    assign b_mem_rdata = (b_mem_re && b_re_cyc == 0) ? (b_mem_addr ^ 32'hC0DE_0000)
                                                     : (32'hBAD1_0000 | 32'(b_re_cyc));

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    logic [31:0] shadow [64];

    typedef struct {
        bit          port;      // 0 = cpu, 1 = dbg
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata; // o_rdata expected at the ack
    } vec_t;

    vec_t vecs [6];

    task automatic set_vec(input int i, input bit p, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] e);
        vecs[i].port = p; vecs[i].we = w; vecs[i].addr = a;
        vecs[i].wdata = d; vecs[i].exp_rdata = e;
    endtask

    task automatic do_reset();
        cpu_req = 0; dbg_req = 0; b_cpu_req = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // One complete single-requester transaction on DUT A, starting from IDLE
    // at a negedge.
    task automatic run_txn(input string tag, input bit port, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata);
        int n, re_n, we_n;
        bit got;
        n = 0; re_n = 0; we_n = 0; got = 0;
        if (port) begin dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
        else      begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        if (we) shadow[addr[7:2]] = wdata;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_re) begin re_n++; check({tag, " rd mem_addr"}, mem_addr, addr); end
            if (mem_we) begin
                we_n++;
                check({tag, " wr mem_addr"}, mem_addr, addr);
                check({tag, " wr mem_wdata"}, mem_wdata, wdata);
            end
            check({tag, " other ack"}, port ? cpu_ack : dbg_ack, 0);
            if (port ? dbg_ack : cpu_ack) got = 1;
        end
        check({tag, " ack seen"}, got, 1);
        check({tag, " ack latency"}, n, LAT + 1);
        check({tag, " mem_re cycles"}, re_n, we ? 0 : LAT);
        check({tag, " mem_we cycles"}, we_n, we ? 1 : 0);
        check({tag, " rdata"}, rdata, exp_rdata);
        cpu_req = 0; dbg_req = 0;
        @(negedge clk);
        check({tag, " ack one cycle"}, {cpu_ack, dbg_ack}, 0);
        check({tag, " idle strobes"}, {mem_re, mem_we}, 0);
    endtask

    // Working variables for the sequences and the random model.
    int          n, cnt, b_n, b_acks;
    bit          pend;
    int          sv_port [3];
    int          sv_cyc  [3];
    int          b_cyc   [2];
    logic [31:0] b_rd    [2];
`ifdef MEM_ARB_RR_EN
    int exp_seq [3] = '{0, 1, 0};
    int last_port;
`else
    int exp_seq [3] = '{1, 1, 1};
`endif
    // Random-phase model state: the current grant and the requester state.
    int          pc, g, d, win;
    bit          busy, done, g_we;
    int          g_port;
    logic [31:0] g_addr, g_wdata, g_rval, m_rdata;
    bit          rq [2];
    bit          rwe [2];
    logic [31:0] rad [2];
    logic [31:0] rwd [2];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        set_vec(0, 0, 0, 32'h10, 32'h0,         32'h1234_5678);
        set_vec(1, 1, 1, 32'h40, 32'hDEAD_BEEF, 32'h1234_5678);
        set_vec(2, 0, 0, 32'h40, 32'h0,         32'hDEAD_BEEF);
        set_vec(3, 1, 0, 32'h10, 32'h0,         32'h1234_5678);
        set_vec(4, 0, 1, 32'h00, 32'hA5A5_0001, 32'h1234_5678);
        set_vec(5, 1, 0, 32'h00, 32'h0,         32'hA5A5_0001);

        // ---- reset values ----
        repeat (2) @(negedge clk);
        check("reset acks", {cpu_ack, dbg_ack}, 0);
        check("reset strobes", {mem_re, mem_we}, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset rdata", rdata, 0);
        check("reset stall", cpu_stall, 0);
        rst_n = 1;
        @(negedge clk);

        // ---- table-driven single transactions ----
        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].we,
                    vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // ---- reset asserted during the second BUSY cycle ----
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        @(negedge clk);
        check("rstbusy first busy re", mem_re, 1);
        check("rstbusy stall", cpu_stall, 1);
        @(negedge clk);
        check("rstbusy second busy re", mem_re, 1);
        rst_n = 0; cpu_req = 0;
        #1;
        check("rstbusy strobes drop", {mem_re, mem_we}, 0);
        check("rstbusy mem_addr", mem_addr, 0);
        check("rstbusy rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) cnt++;
        end
        check("rstbusy no ack", cnt, 0);
        run_txn("post-reset read", 0, 0, 32'h10, 32'h0, 32'h1234_5678);

        // ---- one-cycle cpu pulse during a dbg transaction ----
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
        n = 0; cnt = 0; pend = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) begin cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0; end
            if (n == 2) cpu_req = 0;
            if (cpu_ack) cnt++;
            if (dbg_ack) begin
                check("pulse dbg ack time", n, LAT + 1);
                check("pulse dbg rdata", rdata, 32'hDEAD_BEEF);
                dbg_req = 0;
                pend = 1;
            end
        end
        check("pulse dbg acked", pend, 1);
        check("pulse cpu never acked", cnt, 0);

        // ---- both ports request together and hold ----
        do_reset();
        for (int i = 0; i < 3; i++) begin sv_port[i] = -1; sv_cyc[i] = -1; end
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
        n = 0; cnt = 0;
        while (cnt < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (cpu_ack || dbg_ack) begin
                sv_port[cnt] = dbg_ack ? 1 : 0;
                sv_cyc[cnt]  = n;
                cnt++;
            end
        end
        cpu_req = 0; dbg_req = 0;
        check("both ack count", cnt, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("both ack%0d port", i), sv_port[i], exp_seq[i]);
            check($sformatf("both ack%0d cycle", i), sv_cyc[i], (LAT + 1) + i * (LAT + 2));
        end
        repeat (2) @(negedge clk);

        // ---- LAT=1 back-to-back cpu reads on DUT B ----
        b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h0;
        b_n = 0; b_acks = 0; pend = 0; cnt = 0;
        b_cyc[0] = -1; b_cyc[1] = -1; b_rd[0] = 0; b_rd[1] = 0;
        while (b_acks < 2 && b_n < 20) begin
            @(negedge clk);
            b_n++;
            if (b_mem_re) cnt++;
            if (b_cpu_ack) begin
                b_cyc[b_acks] = b_n;
                b_rd[b_acks]  = b_rdata;
                b_acks++;
                b_cpu_req = 0;
                pend = (b_acks == 1);
            end else if (pend) begin
                b_cpu_req = 1; b_cpu_addr = 32'h4; pend = 0;
            end
        end
        check("lat1 ack count", b_acks, 2);
        check("lat1 ack0 cycle", b_cyc[0], 2);
        check("lat1 ack1 cycle", b_cyc[1], 5);
        check("lat1 rdata0", b_rd[0], 32'hC0DE_0000);
        check("lat1 rdata1", b_rd[1], 32'hC0DE_0004);
        check("lat1 mem_re cycles", cnt, 2);

        // ---- randomized traffic against the transaction model ----
        do_reset();
        pc = 0; g = -100; g_port = 0; g_we = 0; g_addr = 0; g_wdata = 0; g_rval = 0;
        m_rdata = 0;
`ifdef MEM_ARB_RR_EN
        last_port = 1;
`endif
        for (int p = 0; p < 2; p++) begin rq[p] = 0; rwe[p] = 0; rad[p] = 0; rwd[p] = 0; end
        for (int k = 0; k < NRND; k++) begin
            @(negedge clk);
            pc++;
            d    = pc - g;
            busy = (d >= 0) && (d < LAT);
            done = (d == LAT);
            if (done && !g_we) m_rdata = g_rval;

            check("rnd cpu_ack", cpu_ack, done && g_port == 0);
            check("rnd dbg_ack", dbg_ack, done && g_port == 1);
            check("rnd mem_re", mem_re, busy && !g_we);
            check("rnd mem_we", mem_we, busy && d == 0 && g_we);
            check("rnd mem_addr", mem_addr, busy ? g_addr : 32'h0);
            check("rnd mem_wdata", mem_wdata, busy ? g_wdata : 32'h0);
            check("rnd rdata", rdata, m_rdata);
            check("rnd cpu_stall", cpu_stall, rq[0] && !(done && g_port == 0));

            // Requesters: deassert in the ack cycle, raise at random, and
            // sometimes give up on a request that has not been granted yet.
            for (int p = 0; p < 2; p++) begin
                if (done && g_port == p) begin
                    rq[p] = 0;
                end else if (!rq[p]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        rq[p]  = 1;
                        rwe[p] = 1'($urandom_range(0, 1));
                        rad[p] = $urandom();
                        rwd[p] = $urandom();
                    end
                end else if (!(d >= 0 && d <= LAT && g_port == p) && $urandom_range(0, 15) == 0) begin
                    rq[p] = 0;
                end
            end
            cpu_req = rq[0]; cpu_we = rwe[0]; cpu_addr = rad[0]; cpu_wdata = rwd[0];
            dbg_req = rq[1]; dbg_we = rwe[1]; dbg_addr = rad[1]; dbg_wdata = rwd[1];

            // Arbitration at the next edge, if the previous transaction
            // (LAT busy + 1 done + 1 idle cycle) is finished.
            if ((pc + 1 >= g + LAT + 2) && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) begin
`ifdef MEM_ARB_RR_EN
                    win = (last_port == 1) ? 0 : 1;
`else
                    win = 1;
`endif
                end else begin
                    win = rq[1] ? 1 : 0;
                end
`ifdef MEM_ARB_RR_EN
                last_port = win;
`endif
                g       = pc + 1;
                g_port  = win;
                g_we    = rwe[win];
                g_addr  = rad[win];
                g_wdata = rwd[win];
                g_rval  = shadow[g_addr[7:2]];
                if (g_we) shadow[g_addr[7:2]] = g_wdata;
            end
        end
        cpu_req = 0; dbg_req = 0;
        repeat (LAT + 3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
